// File: rtl/snn_conv_act_pool.sv
// Spiking-CNN layer: 3x3 valid convolution over a 16x16 image, integrate-and-fire
// update of 14x14 neurons, then 2x2 spike-count pooling down to 7x7.
module snn_conv_act_pool #(
    parameter int DW = 16,
    parameter int XW = 3,
    parameter logic signed [DW-1:0] THRESH = 16'sd256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [16*16*XW-1:0] x,
    input  logic [9*DW-1:0]     w,
    input  logic signed [DW-1:0] b,
    output logic [14*14*DW-1:0] out,
    output logic [7*7*3-1:0]    out_p,
    input  logic [14*14-1:0]    s_in,
    output logic [14*14-1:0]    s_out,
    input  logic [14*14*DW-1:0] vv_old
);

    localparam int IMG = 16;
    localparam int N   = 14;
    localparam int NN  = N * N;
    localparam int P   = 7;
    // 24 bits holds b + 9 * 7 * (-32768) without overflow.
    localparam int AW  = 24;
    localparam logic signed [AW-1:0] SAT_HI = AW'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

    logic [NN*DW-1:0] conv_d;
    logic [NN*DW-1:0] conv_q;
    logic [NN*DW-1:0] v_d;
    logic [NN-1:0]    spk_d;
    logic [P*P*3-1:0] pool_d;

    always_comb begin
        logic signed [AW-1:0] acc;
        logic signed [AW-1:0] pix;
        logic signed [AW-1:0] tap;
        acc    = '0;
        pix    = '0;
        tap    = '0;
        conv_d = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                acc = AW'(b);
                for (int kr = 0; kr < 3; kr++) begin
                    for (int kc = 0; kc < 3; kc++) begin
                        pix = $signed({{(AW-XW){1'b0}}, x[XW*(IMG*(r+kr)+c+kc) +: XW]});
                        tap = AW'($signed(w[DW*(3*kr+kc) +: DW]));
                        acc = acc + pix * tap;
                    end
                end
                if (acc > SAT_HI)
                    conv_d[DW*(N*r+c) +: DW] = SAT_HI[DW-1:0];
                else if (acc < SAT_LO)
                    conv_d[DW*(N*r+c) +: DW] = SAT_LO[DW-1:0];
                else
                    conv_d[DW*(N*r+c) +: DW] = acc[DW-1:0];
            end
        end
    end

    // A neuron that fired last step integrates from zero; the sum saturates on overflow.
    always_comb begin
        logic [DW-1:0] base;
        logic [DW-1:0] cv;
        logic [DW:0]   sum;
        logic [DW-1:0] v;
        base  = '0;
        cv    = '0;
        sum   = '0;
        v     = '0;
        v_d   = '0;
        spk_d = '0;
        for (int n = 0; n < NN; n++) begin
            base = s_in[n] ? '0 : vv_old[DW*n +: DW];
            cv   = conv_q[DW*n +: DW];
            sum  = {base[DW-1], base} + {cv[DW-1], cv};
            if (sum[DW] != sum[DW-1])
                v = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            else
                v = sum[DW-1:0];
            v_d[DW*n +: DW] = v;
            spk_d[n]        = ($signed(v) >= THRESH);
        end
    end

    always_comb begin
        pool_d = '0;
        for (int pr = 0; pr < P; pr++) begin
            for (int pc = 0; pc < P; pc++) begin
                pool_d[3*(P*pr+pc) +: 3] = 3'(s_out[N*(2*pr)+2*pc])
                                         + 3'(s_out[N*(2*pr)+2*pc+1])
                                         + 3'(s_out[N*(2*pr+1)+2*pc])
                                         + 3'(s_out[N*(2*pr+1)+2*pc+1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_q <= '0;
            out    <= '0;
            s_out  <= '0;
            out_p  <= '0;
        end else begin
            conv_q <= conv_d;
            out    <= v_d;
            s_out  <= spk_d;
            out_p  <= pool_d;
        end
    end

endmodule

// File: tb/tb_snn_conv_act_pool.sv
// Directed bench for snn_conv_act_pool: uniform input patterns with hand-computed
// membrane, spike and pooled-count expectations, plus latency and reset behaviour.
module tb_snn_conv_act_pool;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [767:0]       x;
    logic [143:0]       w;
    logic signed [15:0] b;
    logic [3135:0]      out;
    logic [146:0]       out_p;
    logic [195:0]       s_in;
    logic [195:0]       s_out;
    logic [3135:0]      vv_old;

    int n_checks = 0;
    int n_fail   = 0;

    snn_conv_act_pool dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .w      (w),
        .b      (b),
        .out    (out),
        .out_p  (out_p),
        .s_in   (s_in),
        .s_out  (s_out),
        .vv_old (vv_old)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int xv, input int wv, input int bv, input int vv, input logic sv);
        for (int i = 0; i < 256; i++) x[3*i +: 3] = 3'(xv);
        for (int i = 0; i < 9; i++) w[16*i +: 16] = 16'(wv);
        b = 16'(bv);
        for (int n = 0; n < 196; n++) vv_old[16*n +: 16] = 16'(vv);
        s_in = {196{sv}};
    endtask

    task automatic waitClocks(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Every neuron and pooling cell is expected to hold the same value.
    task automatic checkAll(input string tag, input int eo, input int es, input int ep);
        for (int n = 0; n < 196; n++) begin
            checkOutput($sformatf("%s out[%0d]", tag, n), int'($signed(out[16*n +: 16])), eo);
            checkOutput($sformatf("%s s_out[%0d]", tag, n), int'(s_out[n]), es);
        end
        for (int p = 0; p < 49; p++)
            checkOutput($sformatf("%s out_p[%0d]", tag, p), int'(out_p[3*p +: 3]), ep);
    endtask

    initial begin
        $display("[TB] start");
        rst_n = 1'b0;
        applyStimulus(1, 32, 0, 0, 1'b0);
        #3;
        waitClocks(3);
        checkAll("reset", 0, 0, 0);

        // 9 taps * 1 * 32 = 288 >= 256, so every neuron fires and every cell counts 4.
        rst_n = 1'b1;
        waitClocks(1);
        checkAll("lat1", 0, 0, 0);
        waitClocks(1);
        checkAll("lat2", 288, 1, 0);
        waitClocks(1);
        checkAll("allfire", 288, 1, 4);

        #3 rst_n = 1'b0;
        #1 checkAll("midreset", 0, 0, 0);
        #2 rst_n = 1'b1;
        waitClocks(1);
        checkAll("rel1", 0, 0, 0);
        waitClocks(1);
        checkAll("rel2", 288, 1, 0);

        applyStimulus(0, 0, 100, 0, 1'b0);
        waitClocks(3);
        checkAll("bias", 100, 0, 0);

        applyStimulus(0, 0, 100, 200, 1'b1);
        waitClocks(3);
        checkAll("spkreset", 100, 0, 0);
        s_in = '0;
        waitClocks(3);
        checkAll("integrate", 300, 1, 4);

        applyStimulus(0, 0, 255, 0, 1'b0);
        waitClocks(3);
        checkAll("below_th", 255, 0, 0);
        b = 16'sd256;
        waitClocks(3);
        checkAll("at_th", 256, 1, 4);

        applyStimulus(0, 0, 0, 0, 1'b0);
        x[2:0]  = 3'd7;
        w[15:0] = 16'sd40;
        waitClocks(3);
        for (int n = 0; n < 196; n++) begin
            checkOutput($sformatf("tap out[%0d]", n), int'($signed(out[16*n +: 16])), (n == 0) ? 280 : 0);
            checkOutput($sformatf("tap s_out[%0d]", n), int'(s_out[n]), (n == 0) ? 1 : 0);
        end
        for (int p = 0; p < 49; p++)
            checkOutput($sformatf("tap out_p[%0d]", p), int'(out_p[3*p +: 3]), (p == 0) ? 1 : 0);

        applyStimulus(7, 32767, 32767, 0, 1'b0);
        waitClocks(3);
        checkAll("sat_hi", 32767, 1, 4);
        applyStimulus(7, -32768, -32768, 0, 1'b0);
        waitClocks(3);
        checkAll("sat_lo", -32768, 0, 0);

        // Convolution stays in range; only the membrane add overflows.
        applyStimulus(0, 0, 1000, 32000, 1'b0);
        waitClocks(3);
        checkAll("msat_hi", 32767, 1, 4);
        applyStimulus(0, 0, -1000, -32000, 1'b0);
        waitClocks(3);
        checkAll("msat_lo", -32768, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
